// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I memory-stage load/store unit:
// funct3 width codes, FSM states and exception codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } lsu_state_e;

  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_ILLEGAL  = 2'b10
  } lsu_exc_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enable/replication, load extract and
// sign/zero extension, and misaligned/illegal-width detection.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_offset,
  input  logic [31:0]       rdata,
  output logic              is_mem,
  output logic              is_store,
  output logic              fault,
  output lsu_exc_e          fault_code,
  output logic [ADDR_W-1:0] word_addr,
  output logic [3:0]        be,
  output logic [31:0]       wdata,
  output logic [31:0]       load_data
);

  logic               illegal;
  logic               misaligned;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  // Both read and write asserted is resolved as a store.
  always_comb begin
    is_store   = mem_write;
    is_mem     = mem_read | mem_write;
    illegal    = is_store ? (funct3 >= 3'b011)
                          : (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
    misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: misaligned = addr[0];
      F3_W:        misaligned = (addr[1:0] != 2'b00);
      default:     misaligned = 1'b0;
    endcase
    fault      = is_mem & (illegal | misaligned);
    fault_code = illegal ? EXC_ILLEGAL : (misaligned ? EXC_MISALIGN : EXC_NONE);
    word_addr  = {addr[ADDR_W-1:2], 2'b00};
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = 4'b0001 << addr[1:0];
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = 4'b0011 << {addr[1], 1'b0};
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte   = rdata[{ld_offset, 3'b000} +: 8];
    ld_half   = ld_offset[1] ? rdata[31:16] : rdata[15:0];
    byte_sx   = {{24{ld_byte[7]}}, ld_byte};
    half_sx   = {{16{ld_half[15]}}, ld_half};
    case (ld_funct3)
      F3_B:    load_data = $unsigned(byte_sx);
      F3_BU:   load_data = {24'd0, ld_byte};
      F3_H:    load_data = $unsigned(half_sx);
      F3_HU:   load_data = {16'd0, ld_half};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: drives the data-memory request/grant/response handshake
// and produces the registered MEM/WB writeback bundle or an exception pulse.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [31:0]       ex_alu_result,
  input  logic [31:0]       ex_store_data,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              lsu_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              lsu_exc,
  output logic [1:0]        lsu_exc_code,
  output logic [ADDR_W-1:0] lsu_exc_addr
);

  lsu_state_e        state;
  logic              is_mem;
  logic              is_store;
  logic              fault;
  lsu_exc_e          fault_code;
  logic [ADDR_W-1:0] word_addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       load_data;
  logic              accept;

  logic [4:0]        rd_p1;
  logic              reg_write_p1;
  logic [2:0]        ld_funct3_p1;
  logic [1:0]        ld_offset_p1;

  assign accept    = ex_valid && (state == IDLE);
  assign lsu_stall = (state != IDLE);

  lsu_align #(
    .ADDR_W (ADDR_W)
  ) u_align (
    .mem_read   (ex_mem_read),
    .mem_write  (ex_mem_write),
    .funct3     (ex_funct3),
    .addr       (ex_alu_result[ADDR_W-1:0]),
    .store_data (ex_store_data),
    .ld_funct3  (ld_funct3_p1),
    .ld_offset  (ld_offset_p1),
    .rdata      (dmem_rdata),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .fault      (fault),
    .fault_code (fault_code),
    .word_addr  (word_addr),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data)
  );

  // Stage p1: instruction context held for the duration of a memory access.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_p1        <= ex_rd;
      reg_write_p1 <= ex_reg_write;
      ld_funct3_p1 <= ex_funct3;
      ld_offset_p1 <= ex_alu_result[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= 4'b0000;
      dmem_wdata   <= 32'd0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      lsu_exc      <= 1'b0;
      lsu_exc_code <= 2'b00;
      lsu_exc_addr <= '0;
    end else begin
      wb_valid <= 1'b0;
      lsu_exc  <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= ex_reg_write;
              wb_rd        <= ex_rd;
              wb_data      <= ex_alu_result;
            end else if (fault) begin
              lsu_exc      <= 1'b1;
              lsu_exc_code <= fault_code;
              lsu_exc_addr <= ex_alu_result[ADDR_W-1:0];
            end else begin
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= word_addr;
              dmem_be    <= be;
              dmem_wdata <= wdata;
              state      <= REQ;
            end
          end
        end
        // Request fields stay frozen until the grant arrives.
        REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            if (dmem_we) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= 1'b0;
              wb_rd        <= rd_p1;
              state        <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (dmem_rvalid) begin
            wb_valid     <= 1'b1;
            wb_reg_write <= reg_write_p1;
            wb_rd        <= rd_p1;
            wb_data      <= load_data;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ops push expected writeback or
// exception events; a negedge monitor pops and compares them as they appear.
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [2:0]  ex_funct3 = 3'b000;
  logic [31:0] ex_alu_result = 32'd0;
  logic [31:0] ex_store_data = 32'd0;
  logic [4:0]  ex_rd = 5'd0;
  logic        ex_reg_write = 1'b0;
  logic        lsu_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lsu_exc;
  logic [1:0]  lsu_exc_code;
  logic [31:0] lsu_exc_addr;

  always #5 clk = ~clk;

  mem_stage_lsu #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .lsu_stall    (lsu_stall),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .wb_valid     (wb_valid),
    .wb_reg_write (wb_reg_write),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .lsu_exc      (lsu_exc),
    .lsu_exc_code (lsu_exc_code),
    .lsu_exc_addr (lsu_exc_addr)
  );

  typedef struct {
    bit          is_exc;
    int          due;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    bit          chk_data;
    logic [1:0]  code;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_wb(input int due, input logic [4:0] rd, input logic rw,
                         input logic [31:0] data, input bit chk_data);
    exp_t e;
    e.is_exc = 1'b0; e.due = due; e.rd = rd; e.rw = rw;
    e.data = data; e.chk_data = chk_data; e.code = 2'b00; e.addr = 32'd0;
    sb.push_back(e);
  endtask

  task automatic push_exc(input int due, input logic [1:0] code, input logic [31:0] addr);
    exp_t e;
    e.is_exc = 1'b1; e.due = due; e.rd = 5'd0; e.rw = 1'b0;
    e.data = 32'd0; e.chk_data = 1'b0; e.code = code; e.addr = addr;
    sb.push_back(e);
  endtask

  // Monitor: every wb_valid / lsu_exc pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || lsu_exc)) begin
      chk("wb_exc_exclusive", {31'd0, wb_valid & lsu_exc}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual wb_valid=%b lsu_exc=%b required none", wb_valid, lsu_exc);
      end else begin
        mon_e = sb.pop_front();
        chk("event_cycle", cyc, mon_e.due);
        chk("event_is_exc", {31'd0, lsu_exc}, {31'd0, mon_e.is_exc});
        if (mon_e.is_exc) begin
          chk("exc_code", {30'd0, lsu_exc_code}, {30'd0, mon_e.code});
          chk("exc_addr", lsu_exc_addr, mon_e.addr);
        end else begin
          chk("wb_rd", {27'd0, wb_rd}, {27'd0, mon_e.rd});
          chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, mon_e.rw});
          if (mon_e.chk_data) chk("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  task automatic check_reset(input string nm);
    chk({nm, "_ctrl"}, {15'd0, lsu_stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write,
                        wb_rd, lsu_exc, lsu_exc_code}, 32'd0);
    chk({nm, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({nm, "_dmem_wdata"}, dmem_wdata, 32'd0);
    chk({nm, "_wb_data"}, wb_data, 32'd0);
    chk({nm, "_exc_addr"}, lsu_exc_addr, 32'd0);
  endtask

  // All op tasks start and end #1 after a rising edge.
  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000;
    ex_alu_result = res; ex_rd = rd; ex_reg_write = 1'b1;
    push_wb(cyc + 1, rd, 1'b1, res, 1'b1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk("alu_no_req", {31'd0, dmem_req}, 32'd0);
    chk("alu_no_stall", {31'd0, lsu_stall}, 32'd0);
  endtask

  task automatic mem_op(input string nm, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                        input logic [4:0] rd, input int gw, input int rw,
                        input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_wb, input int e_stall);
    int stall_cnt;
    int due;
    logic st;
    st = wr_en;
    stall_cnt = 0;
    ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_reg_write = 1'b1;
    due = st ? cyc + 2 + gw : cyc + 3 + gw + rw;
    push_wb(due, rd, !st, e_wb, !st);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    for (int i = 0; i <= gw; i++) begin
      chk({nm, "_req"}, {31'd0, dmem_req}, 32'd1);
      chk({nm, "_we"}, {31'd0, dmem_we}, {31'd0, st});
      chk({nm, "_addr"}, dmem_addr, e_addr);
      chk({nm, "_be"}, {28'd0, dmem_be}, {28'd0, e_be});
      if (st) chk({nm, "_wdata"}, dmem_wdata, e_wdata);
      if (lsu_stall) stall_cnt++;
      if (i == gw) dmem_gnt = 1'b1;
      @(posedge clk); #1;
      dmem_gnt = 1'b0;
    end
    if (!st) begin
      for (int i = 0; i <= rw; i++) begin
        chk({nm, "_req_dropped"}, {31'd0, dmem_req}, 32'd0);
        if (lsu_stall) stall_cnt++;
        if (i == rw) begin
          dmem_rvalid = 1'b1;
          dmem_rdata  = rdata;
        end
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
      end
    end
    chk({nm, "_stall_cycles"}, stall_cnt, e_stall);
    chk({nm, "_stall_released"}, {31'd0, lsu_stall}, 32'd0);
  endtask

  task automatic fault_op(input string nm, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [1:0] code);
    ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
    ex_alu_result = addr; ex_store_data = 32'hFFFF_FFFF; ex_rd = 5'd3; ex_reg_write = 1'b1;
    push_exc(cyc + 1, code, addr);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    chk({nm, "_no_req"}, {31'd0, dmem_req}, 32'd0);
    chk({nm, "_no_stall"}, {31'd0, lsu_stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst_n = 1'b1;

    alu_op(32'h0000_1234, 5'd5);
    //      name    rd   wr   f3      addr          sdata         rdata         rd   gw rw  e_addr        be       e_wdata       e_wb          stall
    mem_op("sb",    1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'd0,        5'd6, 2, 0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'd0,        3);
    mem_op("lb",    1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'd0,         32'h0080_0000, 5'd7, 0, 0, 32'h0000_0100, 4'b1111, 32'd0,        32'hFFFF_FF80, 2);
    mem_op("lbu",   1'b1, 1'b0, 3'b100, 32'h0000_0102, 32'd0,         32'h0080_0000, 5'd8, 1, 2, 32'h0000_0100, 4'b1111, 32'd0,        32'h0000_0080, 5);
    mem_op("sh",    1'b0, 1'b1, 3'b001, 32'h0000_0206, 32'h1234_BEEF, 32'd0,        5'd9, 0, 0, 32'h0000_0204, 4'b1100, 32'hBEEF_BEEF, 32'd0,        1);
    mem_op("sw",    1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'd0,        5'd10, 1, 0, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, 32'd0,       2);
    mem_op("lh",    1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0,         32'h8001_7F00, 5'd11, 0, 1, 32'h0000_0100, 4'b1111, 32'd0,       32'hFFFF_8001, 3);
    mem_op("lhu",   1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'd0,         32'h1234_ABCD, 5'd12, 0, 0, 32'h0000_0100, 4'b1111, 32'd0,       32'h0000_ABCD, 2);
    mem_op("lw",    1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'd0,         32'hCAFE_F00D, 5'd13, 0, 0, 32'h0000_0400, 4'b1111, 32'd0,       32'hCAFE_F00D, 2);
    mem_op("rw_sb", 1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h0000_005A, 32'd0,        5'd14, 0, 0, 32'h0000_0000, 4'b0010, 32'h5A5A_5A5A, 32'd0,       1);
    alu_op(32'h0000_0042, 5'd15);

    fault_op("lh_mis",  1'b1, 1'b0, 3'b001, 32'h0000_0101, 2'b01);
    fault_op("lw_mis",  1'b1, 1'b0, 3'b010, 32'h0000_0402, 2'b01);
    fault_op("sh_mis",  1'b0, 1'b1, 3'b001, 32'h0000_0203, 2'b01);
    fault_op("ld_f3_3", 1'b1, 1'b0, 3'b011, 32'h0000_0010, 2'b10);
    fault_op("ld_f3_7", 1'b1, 1'b0, 3'b111, 32'h0000_0003, 2'b10);
    fault_op("st_f3_4", 1'b0, 1'b1, 3'b100, 32'h0000_0010, 2'b10);
    fault_op("rw_f3_6", 1'b1, 1'b1, 3'b110, 32'h0000_0000, 2'b10);

    // Stray grant/response while idle must be ignored.
    dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    @(posedge clk); #1;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    chk("stray_no_req", {31'd0, dmem_req}, 32'd0);
    chk("stray_no_stall", {31'd0, lsu_stall}, 32'd0);
    alu_op(32'h0000_0777, 5'd16);

    // LW abandoned by reset while waiting for its response.
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_funct3 = 3'b010;
    ex_alu_result = 32'h0000_0500; ex_rd = 5'd17; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    chk("lw_rst_wait_stall", {31'd0, lsu_stall}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_reset("midreset");
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    chk("late_rvalid_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("late_rvalid_no_stall", {31'd0, lsu_stall}, 32'd0);
    alu_op(32'h0000_ABCD, 5'd18);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
